// File: rtl/flash_pkg.sv
// Shared widths, constants and FSM state type for the flash read master.
package flash_pkg;

   localparam int unsigned FLASH_ADDR_W = 23;
   localparam int unsigned FLASH_DATA_W = 32;
   localparam int unsigned FLASH_BE_W   = 4;

   localparam logic [5:0] FLASH_BURST_ONE = 6'd1;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWaitData,
      StDone,
      StRelease
   } flash_rd_state_t;

endpackage

// File: rtl/wait_timer.sv
// Saturating cycle timer with a registered, sticky expired flag.
// Expired rises the cycle after the count has sat at TERMINAL_COUNT-1 while enabled.
module wait_timer #(
   parameter int unsigned TERMINAL_COUNT = 1023
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CntW = (TERMINAL_COUNT > 2) ? $clog2(TERMINAL_COUNT) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(TERMINAL_COUNT - 1);

   logic [CntW-1:0] cnt_d, cnt_q;
   logic            expired_d, expired_q;

   always_comb begin
      cnt_d     = cnt_q;
      expired_d = expired_q;
      if (clear_i) begin
         cnt_d     = '0;
         expired_d = 1'b0;
      end else if (enable_i) begin
         // Hold at the terminal value instead of wrapping.
         if (cnt_q == LastCnt) begin
            expired_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/flash_read_ctrl.sv
// Single-word Avalon-MM read master with a bounded wait so a silent flash cannot stall
// the requester; all outputs come straight from flops.
module flash_read_ctrl
   import flash_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [22:0] address,
   input  logic [3:0]  byteenable,
   output logic        done,
   output logic [31:0] data,
   output logic        timeout,
   output logic        flash_mem_read,
   output logic [22:0] flash_mem_address,
   output logic [3:0]  flash_mem_byteenable,
   output logic [5:0]  flash_mem_burstcount,
   input  logic        flash_mem_waitrequest,
   input  logic [31:0] flash_mem_readdata,
   input  logic        flash_mem_readdatavalid
);

   flash_rd_state_t           state_d, state_q;
   logic                      read_d, read_q;
   logic [FLASH_ADDR_W-1:0]   addr_d, addr_q;
   logic [FLASH_BE_W-1:0]     be_d, be_q;
   logic                      done_d, done_q;
   logic                      timeout_d, timeout_q;
   logic [FLASH_DATA_W-1:0]   data_d, data_q;
   logic                      timer_clear;
   logic                      timer_run;
   logic                      expired;

   assign timer_clear = (state_q == StIdle);
   assign timer_run   = (state_q == StReq) || (state_q == StWaitData);

   wait_timer #(
      .TERMINAL_COUNT (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .clear_i   (timer_clear),
      .enable_i  (timer_run),
      .expired_o (expired)
   );

   always_comb begin
      state_d   = state_q;
      read_d    = 1'b0;
      addr_d    = addr_q;
      be_d      = be_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      data_d    = data_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = address;
               be_d    = byteenable;
               read_d  = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            // A forced finish drops read even under waitrequest; timeout flags it.
            if (expired) begin
               data_d    = '0;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               state_d   = StDone;
            end else if (!flash_mem_waitrequest) begin
               state_d = StWaitData;
            end else begin
               read_d = 1'b1;
            end
         end
         StWaitData: begin
            // Real data beats a simultaneous expiry.
            if (flash_mem_readdatavalid) begin
               data_d  = flash_mem_readdata;
               done_d  = 1'b1;
               state_d = StDone;
            end else if (expired) begin
               data_d    = '0;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StRelease;
         end
         StRelease: begin
            if (!start) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         read_q    <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         data_q    <= data_d;
      end
   end

   assign done                 = done_q;
   assign data                 = data_q;
   assign timeout              = timeout_q;
   assign flash_mem_read       = read_q;
   assign flash_mem_address    = addr_q;
   assign flash_mem_byteenable = be_q;
   assign flash_mem_burstcount = FLASH_BURST_ONE;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Scoreboard bench for flash_read_ctrl: stimulus pushes expected completions, monitors
// pop and compare on every done pulse.
module tb_flash_read_ctrl;

   typedef struct {
      logic [31:0] data;
      logic        to;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, start8;
   logic [22:0] address;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        rdv;

   logic        done, timeout, rd;
   logic [31:0] data;
   logic [22:0] addr_o;
   logic [3:0]  be_o;
   logic [5:0]  burst;

   logic        done8, timeout8, rd8;
   logic [31:0] data8;
   logic [22:0] addr8;
   logic [3:0]  be8;
   logic [5:0]  burst8;

   always #5 clk = ~clk;

   flash_read_ctrl #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .start                   (start),
      .address                 (address),
      .byteenable              (byteenable),
      .done                    (done),
      .data                    (data),
      .timeout                 (timeout),
      .flash_mem_read          (rd),
      .flash_mem_address       (addr_o),
      .flash_mem_byteenable    (be_o),
      .flash_mem_burstcount    (burst),
      .flash_mem_waitrequest   (waitrequest),
      .flash_mem_readdata      (readdata),
      .flash_mem_readdatavalid (rdv)
   );

   flash_read_ctrl #(
      .TIMEOUT_CYCLES (8)
   ) dut8 (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .start                   (start8),
      .address                 (address),
      .byteenable              (byteenable),
      .done                    (done8),
      .data                    (data8),
      .timeout                 (timeout8),
      .flash_mem_read          (rd8),
      .flash_mem_address       (addr8),
      .flash_mem_byteenable    (be8),
      .flash_mem_burstcount    (burst8),
      .flash_mem_waitrequest   (waitrequest),
      .flash_mem_readdata      (readdata),
      .flash_mem_readdatavalid (rdv)
   );

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   int          n_rd = 0;
   logic [22:0] exp_addr = '0;
   logic [3:0]  exp_be = '0;
   exp_t        exp_q[$];
   exp_t        exp8_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic push_exp(input bit is8, input logic [31:0] d, input logic to, input int c);
      exp_t e;
      e.data = d;
      e.to   = to;
      e.cyc  = c;
      if (is8) exp8_q.push_back(e);
      else exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: sample mid-cycle, well away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && rd) begin
         n_rd++;
         chk("req_addr_stable", addr_o, exp_addr);
         chk("req_be_stable", be_o, exp_be);
         if (!waitrequest) n_acc++;
      end
      if (timeout && !done) chk("timeout_without_done", timeout, 1'b0);
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("done_data", data, e.data);
            chk("done_timeout", timeout, e.to);
            chk("done_cycle", cyc, e.cyc);
         end
      end
      if (done8) begin
         if (exp8_q.size() == 0) begin
            chk("unexpected_done8", done8, 1'b0);
         end else begin
            e = exp8_q.pop_front();
            chk("done8_data", data8, e.data);
            chk("done8_timeout", timeout8, e.to);
            chk("done8_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic zero_wait_read(input logic [22:0] a, input logic [3:0] b, input logic [31:0] w);
      int c;
      int acc0;
      tick();
      c = cyc;
      start = 1'b1;
      address = a;
      byteenable = b;
      exp_addr = a;
      exp_be = b;
      waitrequest = 1'b0;
      acc0 = n_acc;
      push_exp(1'b0, w, 1'b0, c + 3);
      tick();
      chk("zw_read_high", rd, 1'b1);
      chk("zw_addr", addr_o, a);
      tick();
      chk("zw_read_one_cycle", rd, 1'b0);
      rdv = 1'b1;
      readdata = w;
      tick();
      rdv = 1'b0;
      readdata = '0;
      start = 1'b0;
      tick();
      chk("zw_accepts", n_acc - acc0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int c;
      int acc0;
      int rd0;
      reset_n = 1'b0;
      start = 1'b0;
      start8 = 1'b0;
      address = '0;
      byteenable = '0;
      waitrequest = 1'b0;
      readdata = '0;
      rdv = 1'b0;
      tick();
      tick();
      chk("rst_read", rd, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_data", data, 32'h0);
      chk("rst_address", addr_o, 23'h0);
      chk("rst_byteenable", be_o, 4'h0);
      chk("burstcount", burst, 6'd1);
      reset_n = 1'b1;
      tick();

      // Zero-wait read.
      zero_wait_read(23'h00010, 4'hF, 32'hA1B2C3D4);

      // Five waitrequest cycles, data two cycles after accept; address wiggles mid-request.
      tick();
      c = cyc;
      start = 1'b1;
      address = 23'h12345;
      byteenable = 4'h3;
      exp_addr = 23'h12345;
      exp_be = 4'h3;
      waitrequest = 1'b1;
      acc0 = n_acc;
      push_exp(1'b0, 32'h5A5A0F0F, 1'b0, c + 9);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("wr_read_held", rd, 1'b1);
         if (i == 2) begin
            address = 23'h7AAAA;
            byteenable = 4'hE;
         end
      end
      tick();
      waitrequest = 1'b0;
      chk("wr_read_at_accept", rd, 1'b1);
      tick();
      waitrequest = 1'b1;
      chk("wr_read_after_accept", rd, 1'b0);
      tick();
      rdv = 1'b1;
      readdata = 32'h5A5A0F0F;
      tick();
      rdv = 1'b0;
      readdata = '0;
      chk("wr_single_accept", n_acc - acc0, 1);

      // Start held 20 cycles after done: no new read.
      waitrequest = 1'b0;
      rd0 = n_rd;
      acc0 = n_acc;
      repeat (20) tick();
      chk("hold_no_read", n_rd - rd0, 0);
      chk("hold_no_accept", n_acc - acc0, 0);
      start = 1'b0;
      zero_wait_read(23'h7FFFF, 4'hC, 32'h3C3C1234);

      // Silent flash: forced completion, late data discarded.
      tick();
      c = cyc;
      start = 1'b1;
      address = 23'h00400;
      byteenable = 4'hF;
      exp_addr = 23'h00400;
      exp_be = 4'hF;
      waitrequest = 1'b0;
      push_exp(1'b0, 32'h0, 1'b1, c + 18);
      repeat (18) tick();
      tick();
      rdv = 1'b1;
      readdata = 32'hDEADBEEF;
      tick();
      rdv = 1'b0;
      readdata = '0;
      chk("late_rdv_data", data, 32'h0);
      chk("late_rdv_no_done", done, 1'b0);
      start = 1'b0;
      tick();

      // Flash stuck in waitrequest: read drops when the timer fires.
      tick();
      c = cyc;
      start = 1'b1;
      address = 23'h00777;
      byteenable = 4'h5;
      exp_addr = 23'h00777;
      exp_be = 4'h5;
      waitrequest = 1'b1;
      acc0 = n_acc;
      push_exp(1'b0, 32'h0, 1'b1, c + 18);
      repeat (17) tick();
      chk("req_read_before_expiry", rd, 1'b1);
      tick();
      chk("req_read_dropped", rd, 1'b0);
      tick();
      waitrequest = 1'b0;
      start = 1'b0;
      chk("req_timeout_no_accept", n_acc - acc0, 0);
      tick();

      // Asynchronous reset in the middle of WAIT_DATA.
      zero_wait_read(23'h00123, 4'h9, 32'h0BADF00D);
      tick();
      start = 1'b1;
      address = 23'h00055;
      byteenable = 4'hF;
      exp_addr = 23'h00055;
      exp_be = 4'hF;
      tick();
      tick();
      reset_n = 1'b0;
      start = 1'b0;
      #1;
      chk("arst_read", rd, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_timeout", timeout, 1'b0);
      chk("arst_data", data, 32'h0);
      chk("arst_address", addr_o, 23'h0);
      chk("arst_byteenable", be_o, 4'h0);
      tick();
      reset_n = 1'b1;
      tick();
      rdv = 1'b1;
      readdata = 32'h12345678;
      tick();
      rdv = 1'b0;
      readdata = '0;
      repeat (3) tick();
      chk("post_rst_data", data, 32'h0);
      chk("post_rst_read", rd, 1'b0);

      // Data valid in the very cycle the 8-cycle timer expires.
      tick();
      c = cyc;
      start8 = 1'b1;
      address = 23'h00200;
      byteenable = 4'hF;
      waitrequest = 1'b0;
      push_exp(1'b1, 32'hCAFEF00D, 1'b0, c + 10);
      repeat (9) tick();
      rdv = 1'b1;
      readdata = 32'hCAFEF00D;
      tick();
      rdv = 1'b0;
      readdata = '0;
      start8 = 1'b0;
      repeat (3) tick();

      chk("pending_expected", exp_q.size(), 0);
      chk("pending_expected8", exp8_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
